tpu_sequencer: RTL and testbench
================================

# tpu_sequencer

Control FSM that runs one matrix pass through the TPU datapath. It waits for a weight tile, pops it from the weight FIFO and shifts it into the systolic array with `we_rl`. It then streams `num_rows` input vectors out of the unified buffer and writes the matching deskewed result rows into the result SRAM. It sits beside the UB, weight FIFO, systolic array and result SRAM, and replaces their externally driven enables with a single `start`/`done` handshake.

## Interface
- `ADDRESSSIZE`, 10, width of UB/result SRAM addresses and of `num_rows`
- `MATRIX_SIZE`, 8, array columns; sets the skew/deskew depth
- `NUM_PE_ROWS`, 8, PE rows; sets the `we_rl` shift length and array depth
- `PIPE_LAT`, `1+(MATRIX_SIZE-1)+NUM_PE_ROWS+(MATRIX_SIZE-1)` (23), cycles from a `ub_rd_valid` cycle to its `res_we` cycle

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request a pass; sampled only in IDLE
- `num_rows`  in  ADDRESSSIZE  vectors per pass; latched at start
- `ub_base_addr`  in  ADDRESSSIZE  first UB read address; latched at start
- `res_base_addr`  in  ADDRESSSIZE  first result write address; latched at start
- `fifo_empty`  in  1  weight FIFO empty flag
- `fifo_read_enable`  out  1  weight FIFO pop
- `we_rl`  out  1  systolic weight reload/shift enable
- `ub_addr`  out  ADDRESSSIZE  UB read address
- `ub_rd_valid`  out  1  `ub_addr` is a live read this cycle
- `res_we`  out  1  result SRAM write enable
- `res_addr`  out  ADDRESSSIZE  result SRAM write address
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at pass completion

## Operation
- States: IDLE, WAIT_W, POP, LOAD, FEED, DRAIN, DONE.
- IDLE → WAIT_W: on `start` when `num_rows`≠0. Config is latched on the same edge.
- IDLE → DONE: on `start` when `num_rows`=0. No FIFO, UB or result traffic occurs.
- WAIT_W → POP: when `fifo_empty`=0. The FSM stays in WAIT_W indefinitely while the FIFO is empty.
- POP → LOAD: after one cycle. `fifo_read_enable`=1 in POP only.
- LOAD → FEED: after NUM_PE_ROWS cycles. `we_rl`=1 throughout LOAD.
- FEED → DRAIN: after `num_rows` cycles. During FEED, `ub_rd_valid`=1 and `ub_addr`=base+i with i=0..num_rows-1.
- DRAIN → DONE: when the valid delay line is empty and the last `res_we` has issued.
- DONE → IDLE: after one cycle. `done`=1 in DONE only.
- `res_we` is the PIPE_LAT-deep delayed copy of `ub_rd_valid`.
- `res_addr`=res_base+k, where k counts issued writes.
- Address arithmetic is modulo 2^ADDRESSSIZE; base+i wraps silently.
- `start` while `busy` is ignored. It is not queued.
- Config inputs changing mid-pass have no effect.
- A `fifo_empty` rise after POP has no effect.
- `rst` at any time: FSM→IDLE, delay line and counters cleared. Any partial pass is abandoned with no `done`.

## Timing
- All outputs are registered (Moore-decoded from registered state/counters).
- Reset value of every output is 0.
- `start` sampled at edge 0 (FIFO non-empty): WAIT_W in cycle 1, POP in cycle 2, LOAD in cycles 3..2+NUM_PE_ROWS, then FEED.
- First `res_we` comes exactly PIPE_LAT cycles after the first `ub_rd_valid` cycle.
- Writes are contiguous, `num_rows` cycles long.
- `done` asserts the cycle after the last `res_we`. `busy` drops in the same cycle that `done` falls.
- A new `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- `TPU_SEQ_PERF_CNT_EN` defined: adds output `perf_cycles` [31:0]. It clears on accepted `start`, increments every cycle while `busy`, holds after DONE, and resets to 0.
- `TPU_SEQ_PERF_CNT_EN` undefined: no port and no counter logic.

## Structure
- Shared package `tpu_pkg` holds:
  - the state enum `tpu_seq_state_t`;
  - the PIPE_LAT derivation as a localparam function of MATRIX_SIZE/NUM_PE_ROWS;
  - the address width constant.
- One sub-module, `valid_delay_line`: PIPE_LAT-deep 1-bit shift register with async active-high clear. It provides an `any_pending` OR-reduction output, which DRAIN uses.

## Test plan
- Nominal, defaults (num_rows=4, ub_base=0x010, res_base=0x200, FIFO non-empty, start at cycle 0):
  - `fifo_read_enable` in cycle 2; `we_rl` in cycles 3–10;
  - `ub_addr` 0x010–0x013 in cycles 11–14;
  - `res_we` in cycles 34–37 with `res_addr` 0x200–0x203;
  - `done` in cycle 38.
- FIFO empty for 5 cycles after start: the FSM holds WAIT_W with no `fifo_read_enable`, and all later events shift by exactly 5 cycles.
- num_rows=0: `done` in cycle 1, zero `fifo_read_enable`, `ub_rd_valid` and `res_we`.
- Wrap (ub_base=0x3FE, num_rows=4): `ub_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- `start` re-pulsed during FEED is ignored, and exactly one `done` results. `rst` asserted in cycle 20 drives all outputs to 0 immediately, with no `done` and no further `res_we`.
- With `TPU_SEQ_PERF_CNT_EN`, the nominal case leaves `perf_cycles`=38 after `done`.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU pass sequencer.
// Holds the FSM state enum, address width and pipeline latency derivation.
package tpu_pkg;

  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    POP,
    LOAD,
    FEED,
    DRAIN,
    DONE
  } tpu_seq_state_t;

  // skew + array depth + deskew, plus the UB read register
  function automatic int pipe_lat(input int ms, input int nr);
    return 1 + (ms - 1) + nr + (ms - 1);
  endfunction

  localparam int PIPE_LAT_DEF = pipe_lat(8, 8);

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register tracking reads still in flight
// through the systolic datapath, with asynchronous clear.
module valid_delay_line #(
  parameter int DEPTH = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic delayed,
  output logic any_pending
);

  logic [DEPTH-1:0] line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) line <= '0;
    else     line <= {line[DEPTH-2:0], valid};
  end

  assign delayed = line[DEPTH-1];
  // Excludes the output stage: clear means the line empties next cycle.
  assign any_pending = |line[DEPTH-2:0];

endmodule

// File: rtl/tpu_sequencer.sv
// One-pass control FSM: weight load, UB feed and result write-back.
// Optional TPU_SEQ_PERF_CNT_EN adds a busy-cycle counter port.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDR_W,
  parameter int MATRIX_SIZE = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int PIPE_LAT = pipe_lat(MATRIX_SIZE, NUM_PE_ROWS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] num_rows,
  input  logic [ADDRESSSIZE-1:0] ub_base_addr,
  input  logic [ADDRESSSIZE-1:0] res_base_addr,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_rd_valid,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
`ifdef TPU_SEQ_PERF_CNT_EN
  output logic [31:0]            perf_cycles,
`endif
  output logic                   done
);

  localparam logic [ADDRESSSIZE-1:0] LOAD_LAST =
    ADDRESSSIZE'(NUM_PE_ROWS - 1);

  tpu_seq_state_t state;
  logic [ADDRESSSIZE-1:0] cnt;
  logic [ADDRESSSIZE-1:0] rows;
  logic [ADDRESSSIZE-1:0] ub_base;
  logic [ADDRESSSIZE-1:0] res_base;
  logic [ADDRESSSIZE-1:0] wr_cnt;
  logic                   any_pending;
  logic                   accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rows     <= '0;
      ub_base  <= '0;
      res_base <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            rows     <= num_rows;
            ub_base  <= ub_base_addr;
            res_base <= res_base_addr;
            cnt      <= '0;
            state    <= (num_rows == '0) ? DONE : WAIT_W;
          end
        end
        WAIT_W: begin
          if (!fifo_empty) state <= POP;
        end
        POP: begin
          cnt   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (cnt == LOAD_LAST) begin
            cnt   <= '0;
            state <= FEED;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FEED: begin
          if (cnt == rows - 1'b1) begin
            cnt   <= '0;
            state <= DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!any_pending) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wr_cnt <= '0;
    else if (accept) wr_cnt <= '0;
    else if (res_we) wr_cnt <= wr_cnt + 1'b1;
  end

  valid_delay_line #(
    .DEPTH(PIPE_LAT)
  ) u_vdl (
    .clk        (clk),
    .rst        (rst),
    .valid      (ub_rd_valid),
    .delayed    (res_we),
    .any_pending(any_pending)
  );

  assign fifo_read_enable = (state == POP);
  assign we_rl            = (state == LOAD);
  assign ub_rd_valid      = (state == FEED);
  assign ub_addr          = ub_rd_valid ? ub_base + cnt : '0;
  assign res_addr         = res_base + wr_cnt;
  assign busy             = (state != IDLE);
  assign done             = (state == DONE);

`ifdef TPU_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         perf_cycles <= '0;
    else if (accept) perf_cycles <= '0;
    else if (busy)   perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer using a cycle-timeline model.
// Honors TPU_SEQ_PERF_CNT_EN when defined.
module tb_tpu_sequencer;

  localparam int NPR = 8;
  localparam int PL  = 23;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] num_rows;
  logic [9:0] ub_base_addr;
  logic [9:0] res_base_addr;
  logic       fifo_empty;
  logic       fifo_read_enable;
  logic       we_rl;
  logic [9:0] ub_addr;
  logic       ub_rd_valid;
  logic       res_we;
  logic [9:0] res_addr;
  logic       busy;
  logic       done;
`ifdef TPU_SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int vectors = 0;
  int errors  = 0;

  tpu_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_rows        (num_rows),
    .ub_base_addr    (ub_base_addr),
    .res_base_addr   (res_base_addr),
    .fifo_empty      (fifo_empty),
    .fifo_read_enable(fifo_read_enable),
    .we_rl           (we_rl),
    .ub_addr         (ub_addr),
    .ub_rd_valid     (ub_rd_valid),
    .res_we          (res_we),
    .res_addr        (res_addr),
    .busy            (busy),
`ifdef TPU_SEQ_PERF_CNT_EN
    .perf_cycles     (perf_cycles),
`endif
    .done            (done)
  );

  always #5 clk = ~clk;

  // Cycle 0 carries start; expected events are placed by arithmetic
  // on the pass timeline: POP at 2+e, LOAD, FEED, writes PL later.
  task automatic run_pass(input int n, input logic [9:0] ub,
                          input logic [9:0] rb, input int e,
                          input bit repulse, input int rst_at,
                          input bit tight, input string name);
    int f0, dc, last;
    bit feed, wr;
    logic [15:0] exp_v, got_v;
    logic [9:0] exp_ra;
    f0 = 3 + e + NPR;
    dc = (n == 0) ? 1 : f0 + PL + n;
    if (rst_at > 0) last = rst_at + 30;
    else            last = tight ? dc : dc + 1;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        start         = 1'b1;
        num_rows      = 10'(n);
        ub_base_addr  = ub;
        res_base_addr = rb;
        fifo_empty    = (e > 0);
      end else begin
        start = repulse && n > 0 && c >= f0 && c < f0 + n;
        num_rows      = 10'($urandom);
        ub_base_addr  = 10'($urandom);
        res_base_addr = 10'($urandom);
        if (c <= e)          fifo_empty = 1'b1;
        else if (c == e + 1) fifo_empty = 1'b0;
        else                 fifo_empty = 1'($urandom);
        if (rst_at > 0 && c == rst_at)     rst = 1'b1;
        if (rst_at > 0 && c == rst_at + 2) rst = 1'b0;
      end
      @(negedge clk);
      feed = n > 0 && c >= f0 && c < f0 + n;
      wr   = n > 0 && c >= f0 + PL && c < f0 + PL + n;
      exp_v = {c >= 1 && c <= dc, c == dc,
               n > 0 && c == 2 + e,
               n > 0 && c >= 3 + e && c < 3 + e + NPR,
               feed, wr,
               feed ? ub + 10'(c - f0) : 10'd0};
      if (rst_at > 0 && c >= rst_at) exp_v = '0;
      got_v = {busy, done, fifo_read_enable, we_rl,
               ub_rd_valid, res_we, ub_addr};
      vectors++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d outs got=%h exp=%h",
                 name, c, got_v, exp_v);
      end
      if (exp_v[10]) begin
        exp_ra = rb + 10'(c - f0 - PL);
        vectors++;
        if (res_addr !== exp_ra) begin
          errors++;
          $display("FAIL %s cycle %0d res_addr got=%h exp=%h",
                   name, c, res_addr, exp_ra);
        end
      end
    end
    start = 1'b0;
`ifdef TPU_SEQ_PERF_CNT_EN
    if (rst_at == 0) begin
      vectors++;
      if (perf_cycles !== 32'(dc)) begin
        errors++;
        $display("FAIL %s perf_cycles got=%0d exp=%0d",
                 name, perf_cycles, dc);
      end
    end
`endif
  endtask

  task automatic test_reset();
    logic [15:0] got_v;
    rst = 1'b1;
    start = 1'b0;
    num_rows = '0;
    ub_base_addr = '0;
    res_base_addr = '0;
    fifo_empty = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    got_v = {busy, done, fifo_read_enable, we_rl,
             ub_rd_valid, res_we, ub_addr};
    vectors++;
    if (got_v !== '0 || res_addr !== '0) begin
      errors++;
      $display("FAIL reset outs got=%h res_addr=%h exp=0",
               got_v, res_addr);
    end
`ifdef TPU_SEQ_PERF_CNT_EN
    vectors++;
    if (perf_cycles !== '0) begin
      errors++;
      $display("FAIL reset perf got=%0d exp=0", perf_cycles);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    run_pass(4, 10'h010, 10'h200, 0, 0, 0, 0, "nominal");
  endtask

  task automatic test_fifo_wait();
    run_pass(4, 10'h010, 10'h200, 5, 0, 0, 0, "fifo_wait");
  endtask

  task automatic test_zero_rows();
    run_pass(0, 10'h010, 10'h200, 0, 0, 0, 0, "zero_rows");
  endtask

  task automatic test_wrap();
    run_pass(4, 10'h3FE, 10'h3FD, 0, 0, 0, 0, "wrap");
  endtask

  task automatic test_repulse_reset();
    run_pass(4, 10'h010, 10'h200, 0, 1, 0, 0, "repulse");
    run_pass(4, 10'h010, 10'h200, 0, 1, 20, 0, "reset_mid");
    run_pass(3, 10'h020, 10'h100, 1, 0, 0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_pass(2, 10'h040, 10'h080, 0, 0, 0, 1, "b2b_a");
    run_pass(5, 10'h050, 10'h090, 2, 0, 0, 1, "b2b_b");
    run_pass(1, 10'h060, 10'h0A0, 0, 0, 0, 0, "b2b_c");
  endtask

  task automatic test_random();
    for (int p = 0; p < 25; p++) begin
      run_pass($urandom_range(0, 12), 10'($urandom),
               10'($urandom), $urandom_range(0, 6),
               1'($urandom), 0, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_fifo_wait();
    test_zero_rows();
    test_wrap();
    test_repulse_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
